image_stream_rx: RTL and testbench

- Downstream of the image streaming glue. Consumes the 128-bit AXI-Stream image beats and reassembles each 1024-bit binary image, 8 beats per image.
- Checks framing using TLAST. Double-buffers the completed images.
- Presents whole images with a valid/ready handshake to the convolutional TM inference core.
- Lets the next image stream in while the core is still holding the previous one.

---
 rtl/nn_acc_img_pkg.sv | 25 ++
 rtl/image_stream_rx_if.sv | 25 ++
 rtl/img_pingpong_buf.sv | 54 +++++
 rtl/image_stream_rx.sv | 113 +++++++++++
 tb/tb_image_stream_rx.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_acc_img_pkg.sv
// Shared constants and types for the image stream path (glue + receiver).
package nn_acc_img_pkg;

    localparam int STREAM_WIDTH   = 128;
    localparam int IMG_DATA_WIDTH = 1024;
    localparam int BEATS          = IMG_DATA_WIDTH / STREAM_WIDTH;
    localparam int BEAT_IDX_W     = $clog2(BEATS);
    localparam int ERR_CNT_W      = 8;
    localparam int IMG_CNT_W      = 16;

    typedef enum logic {
        RECV = 1'b0,
        DROP = 1'b1
    } rx_state_e;

    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

    // One beat write into the current write slot.
    typedef struct packed {
        logic                    en;
        beat_idx_t               idx;
        logic [STREAM_WIDTH-1:0] data;
    } beat_wr_t;

endpackage

// File: rtl/image_stream_rx_if.sv
// Stream-in / image-out bundle of the image receiver.
interface image_stream_rx_if;
    import nn_acc_img_pkg::*;

    logic [STREAM_WIDTH-1:0]   tdata;
    logic                      tvalid;
    logic                      tlast;
    logic                      tready;
    logic [IMG_DATA_WIDTH-1:0] image_data;
    logic                      image_valid;
    logic                      image_ready;

    // Producer of beats and consumer of images.
    modport master (
        output tdata, tvalid, tlast, image_ready,
        input  tready, image_data, image_valid
    );

    // The receiver.
    modport slave (
        input  tdata, tvalid, tlast, image_ready,
        output tready, image_data, image_valid
    );

endinterface

// File: rtl/img_pingpong_buf.sv
// Two-slot image buffer: beats are written into the write slot, a commit
// hands the slot to the reader, the reader pops with valid/ready.
module img_pingpong_buf
    import nn_acc_img_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  beat_wr_t                  wr,
    input  logic                      commit,
    input  logic                      abort,
    output logic [1:0]                occupancy,
    output logic [IMG_DATA_WIDTH-1:0] rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready
);

    logic [1:0][IMG_DATA_WIDTH-1:0] slot_q;
    logic                           wr_ptr_q;
    logic                           rd_ptr_q;
    logic [1:0]                     occ_q;
    logic                           pop;

    assign rd_valid  = (occ_q != 2'd0);
    assign pop       = rd_valid && rd_ready;
    assign rd_data   = slot_q[rd_ptr_q];
    assign occupancy = occ_q;

    // Slot storage; an abort scrubs the partial image so stale beats never
    // leak into a later frame. The write slot is never the head slot while
    // occupancy is non-zero, so this cannot disturb a presented image.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slot_q <= '0;
        end else if (abort) begin
            slot_q[wr_ptr_q] <= '0;
        end else if (wr.en) begin
            slot_q[wr_ptr_q][STREAM_WIDTH*wr.idx +: STREAM_WIDTH] <= wr.data;
        end
    end

    // Pointers and occupancy; commit and pop in the same cycle cancel out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (commit) wr_ptr_q <= ~wr_ptr_q;
            if (pop)    rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + {1'b0, commit} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/image_stream_rx.sv
// Reassembles 128-bit stream beats into 1024-bit images, checks TLAST
// framing, and presents double-buffered images to the inference core.
module image_stream_rx
    import nn_acc_img_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    image_stream_rx_if.slave     bus,
    output logic                 o_frame_err_pulse,
    output logic [ERR_CNT_W-1:0] o_frame_err_cnt,
    output logic [IMG_CNT_W-1:0] o_image_cnt
);

    rx_state_e  state_q, state_d;
    beat_idx_t  k_q, k_d;
    logic       rdy_en_q;
    logic [1:0] occ;
    logic       tready;
    logic       beat_ok;
    beat_wr_t   wr;
    logic       commit;
    logic       abort;
    logic       err;

    // Held low through reset and until the first clock after release.
    assign tready     = rdy_en_q && ((state_q == DROP) || (occ != 2'd2));
    assign bus.tready = tready;
    assign beat_ok    = bus.tvalid && tready;

    // Framing FSM: next state, beat index and buffer strobes.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        wr      = '{en: 1'b0, idx: k_q, data: bus.tdata};
        commit  = 1'b0;
        abort   = 1'b0;
        err     = 1'b0;
        if (beat_ok) begin
            case (state_q)
                RECV: begin
                    if (k_q == beat_idx_t'(BEATS-1)) begin
                        k_d = '0;
                        if (bus.tlast) begin
                            wr.en  = 1'b1;
                            commit = 1'b1;
                        end else begin
                            // Frame overran: flush until the sender's TLAST.
                            abort   = 1'b1;
                            err     = 1'b1;
                            state_d = DROP;
                        end
                    end else if (bus.tlast) begin
                        abort = 1'b1;
                        err   = 1'b1;
                        k_d   = '0;
                    end else begin
                        wr.en = 1'b1;
                        k_d   = k_q + 1'b1;
                    end
                end
                DROP: begin
                    k_d = '0;
                    if (bus.tlast) state_d = RECV;
                end
                default: state_d = RECV;
            endcase
        end
    end

    // FSM state, beat index and post-reset ready enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= RECV;
            k_q      <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Error pulse and saturating error count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_frame_err_pulse <= 1'b0;
            o_frame_err_cnt   <= '0;
        end else begin
            o_frame_err_pulse <= err;
            if (err && (o_frame_err_cnt != {ERR_CNT_W{1'b1}}))
                o_frame_err_cnt <= o_frame_err_cnt + 1'b1;
        end
    end

    // Committed image count, free-running wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_image_cnt <= '0;
        else if (commit) o_image_cnt <= o_image_cnt + 1'b1;
    end

    img_pingpong_buf u_buf (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .wr        (wr),
        .commit    (commit),
        .abort     (abort),
        .occupancy (occ),
        .rd_data   (bus.image_data),
        .rd_valid  (bus.image_valid),
        .rd_ready  (bus.image_ready)
    );

endmodule

// File: tb/tb_image_stream_rx.sv
// Bench for image_stream_rx: table of framing cases plus hand sequences,
// images checked against a scoreboard queue on every pop.
module tb_image_stream_rx;
    import nn_acc_img_pkg::*;

    typedef logic [IMG_DATA_WIDTH-1:0] img_t;
    typedef struct {
        string name;
        int    nb;
        int    tl_at;
        bit    img;
        int    err;
    } vec_t;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n = 1'b0;
    logic                 o_frame_err_pulse;
    logic [ERR_CNT_W-1:0] o_frame_err_cnt;
    logic [IMG_CNT_W-1:0] o_image_cnt;

    image_stream_rx_if bus();

    image_stream_rx dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .bus               (bus),
        .o_frame_err_pulse (o_frame_err_pulse),
        .o_frame_err_cnt   (o_frame_err_cnt),
        .o_image_cnt       (o_image_cnt)
    );

    always #5 i_clk = ~i_clk;

    img_t sb[$];
    img_t mon_exp;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_pops = 0;
    int   n_pulses = 0;
    int   cum_img = 0;
    int   cum_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Pop monitor: every accepted image must match the scoreboard head.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_frame_err_pulse) n_pulses++;
            if (bus.image_valid && bus.image_ready) begin
                n_pops++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pop: got image with empty scoreboard, want none");
                end else begin
                    mon_exp = sb.pop_front();
                    if (bus.image_data !== mon_exp) begin
                        n_fail++;
                        for (int k = 0; k < BEATS; k++) begin
                            if (bus.image_data[STREAM_WIDTH*k +: STREAM_WIDTH] !==
                                mon_exp[STREAM_WIDTH*k +: STREAM_WIDTH]) begin
                                $display("FAIL image_data beat %0d: got %h want %h", k,
                                         bus.image_data[STREAM_WIDTH*k +: STREAM_WIDTH],
                                         mon_exp[STREAM_WIDTH*k +: STREAM_WIDTH]);
                                break;
                            end
                        end
                    end
                end
            end
        end
    end

    function automatic logic [STREAM_WIDTH-1:0] rnd_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer one beat; returns 1 ns after the edge that took it.
    task automatic send_beat(input logic [STREAM_WIDTH-1:0] d, input logic l);
        int n = 0;
        bus.tdata  = d;
        bus.tlast  = l;
        bus.tvalid = 1'b1;
        @(negedge i_clk);
        while (!bus.tready && n < 2000) begin
            n++;
            @(negedge i_clk);
        end
        if (n >= 2000) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_timeout: got tready=0 for %0d cycles, want handshake", n);
        end
        @(posedge i_clk);
        #1;
        bus.tvalid = 1'b0;
        bus.tlast  = 1'b0;
    endtask

    // nb beats, tlast on beat tl_at (-1: never); pushes the image if it should commit.
    task automatic send_frame(input int nb, input int tl_at, input bit exp_img,
                              input bit pat, input int duty);
        logic [STREAM_WIDTH-1:0] bt [16];
        img_t img = '0;
        for (int k = 0; k < nb; k++) begin
            bt[k] = pat ? {4{32'(k)}} : rnd_beat();
            if (k < BEATS) img[STREAM_WIDTH*k +: STREAM_WIDTH] = bt[k];
        end
        if (exp_img) sb.push_back(img);
        for (int k = 0; k < nb; k++) begin
            if (duty < 100) begin
                int g = 0;
                while (int'($urandom_range(99)) >= duty && g < 50) begin
                    @(posedge i_clk);
                    #1;
                    g++;
                end
            end
            send_beat(bt[k], k == tl_at);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        chk(name, 64'(sb.size()), 64'd0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        #1;
        sb.delete();
        n_pulses = 0;
        cum_img  = 0;
        cum_err  = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    vec_t vt[6];

    initial begin
        logic [STREAM_WIDTH-1:0] bb [BEATS];
        img_t bimg;
        int   pops0;

        vt[0] = '{"clean_a",      8,  7, 1'b1, 0};
        vt[1] = '{"early_tlast",  4,  3, 1'b0, 1};
        vt[2] = '{"after_early",  8,  7, 1'b1, 0};
        vt[3] = '{"missing_last", 8, -1, 1'b0, 1};
        vt[4] = '{"drop_tail",    5,  4, 1'b0, 0};
        vt[5] = '{"after_drop",   8,  7, 1'b1, 0};

        bus.tdata       = '0;
        bus.tvalid      = 1'b0;
        bus.tlast       = 1'b0;
        bus.image_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid",     64'(bus.image_valid), 64'd0);
        chk("rst_data_zero", 64'(|bus.image_data), 64'd0);
        chk("rst_tready",    64'(bus.tready), 64'd0);
        chk("rst_pulse",     64'(o_frame_err_pulse), 64'd0);
        chk("rst_err_cnt",   64'(o_frame_err_cnt), 64'd0);
        chk("rst_img_cnt",   64'(o_image_cnt), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("tready_before_edge", 64'(bus.tready), 64'd0);
        @(posedge i_clk);
        #1;
        chk("tready_after_edge", 64'(bus.tready), 64'd1);

        // Pattern frame: valid for exactly one cycle with ready held high.
        bus.image_ready = 1'b1;
        send_frame(8, 7, 1'b1, 1'b1, 100);
        chk("pat_valid_after_last", 64'(bus.image_valid), 64'd1);
        chk("pat_beat7_top", bus.image_data[IMG_DATA_WIDTH-1 -: 64], {32'd7, 32'd7});
        chk("pat_beat0_low", bus.image_data[63:0], 64'd0);
        chk("pat_img_cnt", 64'(o_image_cnt), 64'd1);
        @(negedge i_clk);
        @(posedge i_clk);
        #1;
        chk("pat_valid_one_cycle", 64'(bus.image_valid), 64'd0);
        chk("pat_pops", 64'(n_pops), 64'd1);
        chk("pat_no_err", 64'(o_frame_err_cnt), 64'd0);
        cum_img = 1;

        // Framing table.
        for (int i = 0; i < 6; i++) begin
            send_frame(vt[i].nb, vt[i].tl_at, vt[i].img, 1'b0, 100);
            cum_img += vt[i].img ? 1 : 0;
            cum_err += vt[i].err;
            wait_drain({vt[i].name, "_drain"});
            chk({vt[i].name, "_img_cnt"}, 64'(o_image_cnt), 64'(cum_img));
            chk({vt[i].name, "_err_cnt"}, 64'(o_frame_err_cnt), 64'(cum_err));
            chk({vt[i].name, "_pulses"},  64'(n_pulses), 64'(cum_err));
        end

        // Backpressure: two images buffered, third stalls until the core drains.
        bus.image_ready = 1'b0;
        pops0 = n_pops;
        fork
            begin
                for (int f = 0; f < 3; f++) send_frame(8, 7, 1'b1, 1'b0, 100);
            end
            begin
                int n = 0;
                while (o_image_cnt != IMG_CNT_W'(cum_img + 2) && n < 500) begin
                    @(negedge i_clk);
                    n++;
                end
                chk("bp_two_commits", 64'(o_image_cnt), 64'(cum_img + 2));
                @(negedge i_clk);
                chk("bp_tready_full", 64'(bus.tready), 64'd0);
                chk("bp_valid_full",  64'(bus.image_valid), 64'd1);
                repeat (10) @(negedge i_clk);
                chk("bp_stalled_cnt", 64'(o_image_cnt), 64'(cum_img + 2));
                chk("bp_no_pops",     64'(n_pops), 64'(pops0));
                @(posedge i_clk);
                #1;
                bus.image_ready = 1'b1;
            end
        join
        cum_img += 3;
        wait_drain("bp_drain");
        chk("bp_pops", 64'(n_pops), 64'(pops0 + 3));
        chk("bp_img_cnt", 64'(o_image_cnt), 64'(cum_img));

        // Commit and pop on the same edge with one image buffered.
        bus.image_ready = 1'b0;
        send_frame(8, 7, 1'b1, 1'b0, 100);
        cum_img++;
        bimg = '0;
        for (int k = 0; k < BEATS; k++) begin
            bb[k] = rnd_beat();
            bimg[STREAM_WIDTH*k +: STREAM_WIDTH] = bb[k];
        end
        sb.push_back(bimg);
        for (int k = 0; k < BEATS-1; k++) send_beat(bb[k], 1'b0);
        pops0 = n_pops;
        bus.tdata       = bb[BEATS-1];
        bus.tlast       = 1'b1;
        bus.tvalid      = 1'b1;
        bus.image_ready = 1'b1;
        @(negedge i_clk);
        chk("sim_tready", 64'(bus.tready), 64'd1);
        chk("sim_valid",  64'(bus.image_valid), 64'd1);
        @(posedge i_clk);
        #1;
        bus.tvalid      = 1'b0;
        bus.tlast       = 1'b0;
        bus.image_ready = 1'b0;
        cum_img++;
        @(negedge i_clk);
        chk("sim_pop_count",  64'(n_pops), 64'(pops0 + 1));
        chk("sim_still_valid", 64'(bus.image_valid), 64'd1);
        chk("sim_occ_one",    64'(bus.tready), 64'd1);
        chk("sim_new_head",   64'(bus.image_data == bimg), 64'd1);
        chk("sim_img_cnt",    64'(o_image_cnt), 64'(cum_img));
        @(posedge i_clk);
        #1;
        bus.image_ready = 1'b1;
        wait_drain("sim_drain");

        // Reset mid-frame with one image buffered.
        bus.image_ready = 1'b0;
        send_frame(8, 7, 1'b1, 1'b0, 100);
        for (int k = 0; k < 4; k++) send_beat(rnd_beat(), 1'b0);
        i_rst_n = 1'b0;
        #1;
        chk("mrst_valid",   64'(bus.image_valid), 64'd0);
        chk("mrst_data",    64'(|bus.image_data), 64'd0);
        chk("mrst_tready",  64'(bus.tready), 64'd0);
        chk("mrst_err_cnt", 64'(o_frame_err_cnt), 64'd0);
        chk("mrst_img_cnt", 64'(o_image_cnt), 64'd0);
        do_reset();
        bus.image_ready = 1'b1;
        send_frame(8, 7, 1'b1, 1'b0, 100);
        wait_drain("mrst_drain");
        chk("mrst_next_img", 64'(o_image_cnt), 64'd1);
        chk("mrst_next_err", 64'(o_frame_err_cnt), 64'd0);
        chk("mrst_pulses",   64'(n_pulses), 64'd0);

        // Sparse tvalid over 20 frames.
        do_reset();
        pops0 = n_pops;
        bus.image_ready = 1'b1;
        for (int f = 0; f < 20; f++) send_frame(8, 7, 1'b1, 1'b0, 30);
        wait_drain("gap_drain");
        chk("gap_img_cnt", 64'(o_image_cnt), 64'd20);
        chk("gap_err_cnt", 64'(o_frame_err_cnt), 64'd0);
        chk("gap_pops",    64'(n_pops), 64'(pops0 + 20));

        // Error counter saturation: 256 single-beat early-tlast frames.
        do_reset();
        for (int f = 0; f < 256; f++) send_beat(rnd_beat(), 1'b1);
        repeat (2) @(posedge i_clk);
        #1;
        chk("sat_err_cnt", 64'(o_frame_err_cnt), 64'd255);
        chk("sat_pulses",  64'(n_pulses), 64'd256);
        chk("sat_no_img",  64'(o_image_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
